// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg: shared state encoding, mode constants and legacy defaults for the sequence generator
package seq_gen_pkg;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;
   localparam logic MODE_LOOP    = 1'b0;
   localparam logic MODE_ONESHOT = 1'b1;
   localparam logic [15:0] SEQ_DEF_PAT = 16'h0027;
   localparam int          SEQ_DEF_LEN = 7;
endpackage

// File: rtl/seq_gen_prog_if.sv
// seq_gen_prog_if: control, configuration and serial-output bundle between test control and the generator
interface seq_gen_prog_if #(parameter int LEN_W = 4);
   localparam int MAX_LEN = 2 ** LEN_W;
   logic               seq_en;
   logic               cfg_load;
   logic [MAX_LEN-1:0] cfg_pat;
   logic [LEN_W-1:0]   cfg_len;
   logic               cfg_mode;
   logic               start;
   logic               stop;
   logic               seq_signal;
   logic               seq_valid;
   logic               seq_wrap;
   logic               seq_done;
   logic               busy;
   modport master (
      output seq_en, cfg_load, cfg_pat, cfg_len, cfg_mode, start, stop,
      input  seq_signal, seq_valid, seq_wrap, seq_done, busy
   );
   modport slave (
      input  seq_en, cfg_load, cfg_pat, cfg_len, cfg_mode, start, stop,
      output seq_signal, seq_valid, seq_wrap, seq_done, busy
   );
endinterface

// File: rtl/seq_cfg_shadow.sv
// seq_cfg_shadow: pattern/length/mode shadow registers with load gating and a same-cycle start bypass
module seq_cfg_shadow
   import seq_gen_pkg::*;
#(
   parameter int          LEN_W    = 4,
   parameter int          MAX_LEN  = 2 ** LEN_W,
   parameter logic [15:0] DEF_PAT  = SEQ_DEF_PAT,
   parameter int          DEF_LEN  = SEQ_DEF_LEN,
   parameter logic        DEF_MODE = MODE_LOOP
) (
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   input  logic               accept,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pat,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_mode,
   output logic [MAX_LEN-1:0] act_pat,
   output logic [LEN_W-1:0]   act_len,
   output logic               act_mode
);
   logic [MAX_LEN-1:0] pat;
   logic [LEN_W-1:0]   len;
   logic               mode;
   logic               take;

   assign take = accept & cfg_load;

   // capture a new configuration only while no sequence is running
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         pat  <= MAX_LEN'(DEF_PAT);
         len  <= LEN_W'(DEF_LEN);
         mode <= DEF_MODE;
      end else if (take) begin
         pat  <= cfg_pat;
         len  <= cfg_len;
         mode <= cfg_mode;
      end
   end

   assign act_pat  = take ? cfg_pat  : pat;
   assign act_len  = take ? cfg_len  : len;
   assign act_mode = take ? cfg_mode : mode;
endmodule

// File: rtl/seq_gen_prog.sv
// seq_gen_prog: programmable LSB-first serial bit-sequence generator with loop and one-shot modes
module seq_gen_prog
   import seq_gen_pkg::*;
#(
   parameter int          LEN_W    = 4,
   parameter logic [15:0] DEF_PAT  = SEQ_DEF_PAT,
   parameter int          DEF_LEN  = SEQ_DEF_LEN,
   parameter logic        DEF_MODE = MODE_LOOP
) (
   input logic          sys_clk,
   input logic          sys_rst_n,
   seq_gen_prog_if.slave bus
);
   localparam int MAX_LEN = 2 ** LEN_W;

   logic [1:0]         state;
   logic [LEN_W-1:0]   idx;
   logic               seq_signal;
   logic               seq_valid;
   logic               seq_wrap;
   logic               seq_done;
   logic [MAX_LEN-1:0] act_pat;
   logic [LEN_W-1:0]   act_len;
   logic               act_mode;
   logic               last;

   seq_cfg_shadow #(
      .LEN_W    (LEN_W),
      .MAX_LEN  (MAX_LEN),
      .DEF_PAT  (DEF_PAT),
      .DEF_LEN  (DEF_LEN),
      .DEF_MODE (DEF_MODE)
   ) u_cfg (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .accept    (state != ST_RUN),
      .cfg_load  (bus.cfg_load),
      .cfg_pat   (bus.cfg_pat),
      .cfg_len   (bus.cfg_len),
      .cfg_mode  (bus.cfg_mode),
      .act_pat   (act_pat),
      .act_len   (act_len),
      .act_mode  (act_mode)
   );

   assign last = (idx == act_len);

   // sequencing FSM: stop overrides everything, start only from IDLE/DONE, one bit per enabled RUN cycle
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state      <= ST_IDLE;
         idx        <= '0;
         seq_signal <= 1'b0;
         seq_valid  <= 1'b0;
         seq_wrap   <= 1'b0;
         seq_done   <= 1'b0;
      end else if (bus.stop) begin
         state      <= ST_IDLE;
         idx        <= '0;
         seq_signal <= 1'b0;
         seq_valid  <= 1'b0;
         seq_wrap   <= 1'b0;
         seq_done   <= 1'b0;
      end else if (state != ST_RUN) begin
         seq_valid <= 1'b0;
         seq_wrap  <= 1'b0;
         seq_done  <= 1'b0;
         if (bus.start) begin
            state <= ST_RUN;
            idx   <= '0;
         end
      end else if (bus.seq_en) begin
         seq_signal <= act_pat[idx];
         seq_valid  <= 1'b1;
         seq_wrap   <= last && (act_mode == MODE_LOOP);
         seq_done   <= last && (act_mode == MODE_ONESHOT);
         idx        <= last ? '0 : idx + LEN_W'(1);
         if (last && act_mode == MODE_ONESHOT) state <= ST_DONE;
      end else begin
         seq_valid <= 1'b0;
         seq_wrap  <= 1'b0;
         seq_done  <= 1'b0;
      end
   end

   assign bus.seq_signal = seq_signal;
   assign bus.seq_valid  = seq_valid;
   assign bus.seq_wrap   = seq_wrap;
   assign bus.seq_done   = seq_done;
   assign bus.busy       = (state == ST_RUN);
endmodule

// File: tb/tb_seq_gen_prog.sv
// tb_seq_gen_prog: vector table, directed corner sequences and randomized run against a queue-based model
module tb_seq_gen_prog;
   logic sys_clk = 1'b0;
   logic sys_rst_n = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;

   seq_gen_prog_if #(.LEN_W(4)) bus ();

   seq_gen_prog dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .bus       (bus.slave)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      logic        en, st, sp, ld;
      logic [15:0] pat;
      logic [3:0]  len;
      logic        mode;
      logic        sig, val, wrap, done, busy;
   } vec_t;

   vec_t tbl[$];
   bit legacy[8] = '{1, 1, 1, 0, 0, 1, 0, 0};
   bit a5[16] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 1, 0, 0, 1, 0, 1};

   // reference model state
   bit       m_run;
   bit [15:0] m_pat;
   int       m_len;
   bit       m_mode;
   bit       bits[$];
   int       m_cnt;
   bit       e_sig, e_val, e_wrap, e_done;

   task automatic cmp(input string name, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic expect_out(input string tag, input logic sig, val, wrap, done, busy);
      cmp({tag, ".seq_signal"}, bus.seq_signal, sig);
      cmp({tag, ".seq_valid"}, bus.seq_valid, val);
      cmp({tag, ".seq_wrap"}, bus.seq_wrap, wrap);
      cmp({tag, ".seq_done"}, bus.seq_done, done);
      cmp({tag, ".busy"}, bus.busy, busy);
   endtask

   task automatic drive(input logic en, st, sp, ld, input logic [15:0] p, input logic [3:0] l, input logic m);
      bus.seq_en = en;
      bus.start = st;
      bus.stop = sp;
      bus.cfg_load = ld;
      bus.cfg_pat = p;
      bus.cfg_len = l;
      bus.cfg_mode = m;
   endtask

   task automatic cyc(input logic en, st, sp, ld, input logic [15:0] p, input logic [3:0] l, input logic m);
      @(negedge sys_clk);
      drive(en, st, sp, ld, p, l, m);
      @(posedge sys_clk);
      #1;
   endtask

   task automatic model_reset();
      m_run = 0;
      m_pat = 16'h0027;
      m_len = 7;
      m_mode = 0;
      m_cnt = 0;
      bits.delete();
      {e_sig, e_val, e_wrap, e_done} = '0;
   endtask

   // expected behaviour: a started run is the list of len+1 pattern bits, consumed one per enabled cycle
   task automatic model_step(input bit en, st, sp, ld, input bit [15:0] p, input int l, input bit m);
      e_val = 0;
      e_wrap = 0;
      e_done = 0;
      if (!m_run && ld) begin
         m_pat = p;
         m_len = l;
         m_mode = m;
      end
      if (sp) begin
         m_run = 0;
         e_sig = 0;
      end else if (!m_run) begin
         if (st) begin
            m_run = 1;
            m_cnt = 0;
            bits.delete();
            for (int i = 0; i <= m_len; i++) bits.push_back(m_pat[i]);
         end
      end else if (en) begin
         e_sig = bits[m_cnt % bits.size()];
         e_val = 1;
         if ((m_cnt + 1) % bits.size() == 0) begin
            if (m_mode) begin
               e_done = 1;
               m_run = 0;
            end else e_wrap = 1;
         end
         m_cnt++;
      end
   endtask

   task automatic do_reset();
      @(negedge sys_clk);
      drive(0, 0, 0, 0, 16'h0, 4'h0, 0);
      sys_rst_n = 1'b0;
      #2;
      sys_rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      drive(0, 0, 0, 0, 16'h0, 4'h0, 0);
      #12;
      expect_out("reset", 0, 0, 0, 0, 0);
      sys_rst_n = 1'b1;

      // legacy default loop, then one-shot A5F0 loaded together with start
      tbl.push_back('{1, 1, 0, 0, 16'h0, 4'h0, 0, 0, 0, 0, 0, 1});
      for (int i = 0; i < 16; i++)
         tbl.push_back('{1, 0, 0, 0, 16'h0, 4'h0, 0, legacy[i % 8], 1, (i % 8 == 7), 0, 1});
      tbl.push_back('{0, 0, 1, 0, 16'h0, 4'h0, 0, 0, 0, 0, 0, 0});
      tbl.push_back('{1, 1, 0, 1, 16'hA5F0, 4'd15, 1, 0, 0, 0, 0, 1});
      for (int i = 0; i < 16; i++)
         tbl.push_back('{1, 0, 0, 0, 16'h0, 4'h0, 0, a5[i], 1, 0, (i == 15), (i != 15)});
      tbl.push_back('{1, 0, 0, 0, 16'h0, 4'h0, 0, 1, 0, 0, 0, 0});
      for (int i = 0; i < tbl.size(); i++) begin
         cyc(tbl[i].en, tbl[i].st, tbl[i].sp, tbl[i].ld, tbl[i].pat, tbl[i].len, tbl[i].mode);
         expect_out($sformatf("vec%0d", i), tbl[i].sig, tbl[i].val, tbl[i].wrap, tbl[i].done, tbl[i].busy);
      end

      // gated enable, loop len 3 pattern 1011
      do_reset();
      cyc(0, 1, 0, 1, 16'h000B, 4'd3, 0);
      expect_out("gate.start", 0, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 16'h0, 4'h0, 0); expect_out("gate.e1", 1, 1, 0, 0, 1);
      cyc(0, 0, 0, 0, 16'h0, 4'h0, 0); expect_out("gate.d1", 1, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 16'h0, 4'h0, 0); expect_out("gate.e2", 1, 1, 0, 0, 1);
      cyc(1, 0, 0, 0, 16'h0, 4'h0, 0); expect_out("gate.e3", 0, 1, 0, 0, 1);
      cyc(0, 0, 0, 0, 16'h0, 4'h0, 0); expect_out("gate.d2", 0, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 16'h0, 4'h0, 0); expect_out("gate.e4", 1, 1, 1, 0, 1);

      // load while running is discarded, also for the following start
      cyc(1, 0, 0, 1, 16'h0000, 4'd0, 1); expect_out("runload.e", 1, 1, 0, 0, 1);
      cyc(0, 0, 1, 0, 16'h0, 4'h0, 0); expect_out("runload.stop", 0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 16'h0, 4'h0, 0); expect_out("runload.start", 0, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 16'h0, 4'h0, 0); expect_out("runload.b0", 1, 1, 0, 0, 1);
      cyc(1, 0, 0, 0, 16'h0, 4'h0, 0); expect_out("runload.b1", 1, 1, 0, 0, 1);
      cyc(1, 0, 0, 0, 16'h0, 4'h0, 0); expect_out("runload.b2", 0, 1, 0, 0, 1);
      cyc(1, 0, 0, 0, 16'h0, 4'h0, 0); expect_out("runload.b3", 1, 1, 1, 0, 1);

      // stop together with start on the last one-shot bit
      cyc(0, 0, 1, 0, 16'h0, 4'h0, 0);
      cyc(0, 1, 0, 1, 16'h0005, 4'd2, 1); expect_out("stoplast.start", 0, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 16'h0, 4'h0, 0); expect_out("stoplast.b0", 1, 1, 0, 0, 1);
      cyc(1, 0, 0, 0, 16'h0, 4'h0, 0); expect_out("stoplast.b1", 0, 1, 0, 0, 1);
      cyc(1, 1, 1, 0, 16'h0, 4'h0, 0); expect_out("stoplast.b2", 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 16'h0, 4'h0, 0); expect_out("stoplast.idle", 0, 0, 0, 0, 0);

      // one-bit loop wraps on every enabled cycle
      cyc(0, 1, 0, 1, 16'h0001, 4'd0, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(1, 0, 0, 0, 16'h0, 4'h0, 0);
         expect_out($sformatf("len0.%0d", i), 1, 1, 1, 0, 1);
      end
      cyc(0, 0, 1, 0, 16'h0, 4'h0, 0);

      // asynchronous reset mid-run restores the legacy configuration
      cyc(0, 1, 0, 1, 16'hFFFF, 4'd5, 1);
      cyc(1, 0, 0, 0, 16'h0, 4'h0, 0); expect_out("arst.b0", 1, 1, 0, 0, 1);
      cyc(1, 0, 0, 0, 16'h0, 4'h0, 0);
      #1;
      sys_rst_n = 1'b0;
      #1;
      expect_out("arst.async", 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 16'h0, 4'h0, 0);
      #1;
      sys_rst_n = 1'b1;
      cyc(1, 1, 0, 0, 16'h0, 4'h0, 0); expect_out("arst.start", 0, 0, 0, 0, 1);
      for (int i = 0; i < 8; i++) begin
         cyc(1, 0, 0, 0, 16'h0, 4'h0, 0);
         expect_out($sformatf("arst.b%0d", i), legacy[i], 1, (i == 7), 0, 1);
      end

      // randomized traffic against the model
      do_reset();
      for (int i = 0; i < 2000; i++) begin
         bit en, st, sp, ld, m;
         bit [15:0] p;
         bit [3:0] l;
         en = ($urandom_range(99) < 75);
         st = ($urandom_range(99) < 12);
         sp = ($urandom_range(99) < 3);
         ld = ($urandom_range(99) < 10);
         p = 16'($urandom);
         l = 4'($urandom_range(15));
         m = 1'($urandom_range(1));
         cyc(en, st, sp, ld, p, l, m);
         model_step(en, st, sp, ld, p, int'(l), m);
         expect_out($sformatf("rand%0d", i), e_sig, e_val, e_wrap, e_done, m_run);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
